// File: rtl/nt_mon_pkg.sv
// Shared types and defaults for the node activity monitor family.
package nt_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_COUNT  = 2'd2,
    ST_REPORT = 2'd3
  } mon_state_e;

  localparam int unsigned WIN_LEN_DEF     = 256;
  localparam int unsigned RARE_THRESH_DEF = 4;
  localparam int unsigned STUCK_LEN_DEF   = 64;

  // Bits needed to hold values 0..max_val inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/nt_run_length_tracker.sv
// Tracks the previous sample and the current equal-value run; flags the
// single edge on which a run reaches STUCK_LEN.
module nt_run_length_tracker
  import nt_mon_pkg::*;
#(
  parameter int unsigned STUCK_LEN = STUCK_LEN_DEF,
  parameter int unsigned RUN_W     = cnt_width(STUCK_LEN)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic step_i,
  input  logic bit_i,
  output logic prev_o,
  output logic stuck_hit_o
);

  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STUCK_LEN);
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

  logic             prev_q, prev_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             same;

  assign same = (bit_i == prev_q);

  always_comb begin
    prev_d = prev_q;
    run_d  = run_q;
    if (load_i) begin
      prev_d = bit_i;
      run_d  = RUN_ONE;
    end else if (step_i) begin
      prev_d = bit_i;
      if (!same) begin
        run_d = RUN_ONE;
      end else if (run_q != RUN_MAX) begin
        run_d = run_q + RUN_ONE;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      prev_q <= 1'b0;
      run_q  <= '0;
    end else begin
      prev_q <= prev_d;
      run_q  <= run_d;
    end
  end

  // Saturation at RUN_MAX keeps this to one pulse per run.
  assign stuck_hit_o = step_i && same && (run_q == (RUN_MAX - RUN_ONE));
  assign prev_o      = prev_q;

endmodule

// File: rtl/nt_node_activity_monitor.sv
// Windowed ones/toggle counter for a single observed node with sticky
// rare-window and stuck-node flags.
module nt_node_activity_monitor
  import nt_mon_pkg::*;
#(
  parameter int unsigned WIN_LEN     = WIN_LEN_DEF,
  parameter int unsigned CNT_W       = cnt_width(WIN_LEN),
  parameter int unsigned RARE_THRESH = RARE_THRESH_DEF,
  parameter int unsigned STUCK_LEN   = STUCK_LEN_DEF,
  parameter int unsigned RUN_W       = cnt_width(STUCK_LEN)
) (
  input  logic             I1470_clk,
  input  logic             I1477_rst,
  input  logic             node_in,
  input  logic             sample_en,
  input  logic             start,
  input  logic             cont,
  input  logic             abort,
  input  logic             clr,
  output logic             busy,
  output logic             win_valid,
  output logic [CNT_W-1:0] ones_cnt,
  output logic [CNT_W-1:0] toggle_cnt,
  output logic             rare_flag,
  output logic             stuck_flag
);

  localparam logic [CNT_W-1:0] WIN_C = CNT_W'(WIN_LEN);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  mon_state_e       state_q, state_d;
  logic [CNT_W-1:0] ones_q, toggles_q, idx_q;
  logic [CNT_W-1:0] ones_nxt, toggles_nxt, idx_nxt;
  logic [CNT_W-1:0] ones_cnt_q, toggle_cnt_q;
  logic             rare_flag_q, stuck_flag_q;
  logic             prev_bit, stuck_hit;
  logic             arm_load, count_step, win_done, rare_hit;
  logic [31:0]      ones_ext;

  assign arm_load    = (state_q == ST_ARMED) && sample_en && !abort;
  assign count_step  = (state_q == ST_COUNT) && sample_en && !abort;
  assign ones_nxt    = ones_q + CNT_W'(node_in);
  assign toggles_nxt = toggles_q + CNT_W'(node_in ^ prev_bit);
  assign idx_nxt     = idx_q + ONE_C;
  assign win_done    = count_step && (idx_nxt == WIN_C);
  assign ones_ext    = 32'(ones_nxt);
  assign rare_hit    = win_done && ((ones_ext <= RARE_THRESH) ||
                                    ((WIN_LEN - ones_ext) <= RARE_THRESH));

  nt_run_length_tracker #(
    .STUCK_LEN (STUCK_LEN),
    .RUN_W     (RUN_W)
  ) u_run (
    .clk_i       (I1470_clk),
    .rst_ni      (I1477_rst),
    .load_i      (arm_load),
    .step_i      (count_step),
    .bit_i       (node_in),
    .prev_o      (prev_bit),
    .stuck_hit_o (stuck_hit)
  );

  always_ff @(posedge I1470_clk) begin
    if (!I1477_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (start) state_d = ST_ARMED;
      ST_ARMED:  if (abort) state_d = ST_IDLE;
                 else if (sample_en) state_d = ST_COUNT;
      ST_COUNT:  if (abort) state_d = ST_IDLE;
                 else if (win_done) state_d = ST_REPORT;
      ST_REPORT: if (abort) state_d = ST_IDLE;
                 else state_d = cont ? ST_ARMED : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != ST_IDLE);
    win_valid = (state_q == ST_REPORT);
  end

  always_ff @(posedge I1470_clk) begin
    if (!I1477_rst) begin
      ones_q       <= '0;
      toggles_q    <= '0;
      idx_q        <= '0;
      ones_cnt_q   <= '0;
      toggle_cnt_q <= '0;
      rare_flag_q  <= 1'b0;
      stuck_flag_q <= 1'b0;
    end else begin
      if (arm_load) begin
        ones_q    <= CNT_W'(node_in);
        toggles_q <= '0;
        idx_q     <= ONE_C;
      end else if (count_step) begin
        ones_q    <= ones_nxt;
        toggles_q <= toggles_nxt;
        idx_q     <= idx_nxt;
      end
      if (win_done) begin
        ones_cnt_q   <= ones_nxt;
        toggle_cnt_q <= toggles_nxt;
      end
      // A set event on the same edge as clr takes precedence.
      rare_flag_q  <= rare_hit  || (rare_flag_q  && !clr);
      stuck_flag_q <= stuck_hit || (stuck_flag_q && !clr);
    end
  end

  assign ones_cnt   = ones_cnt_q;
  assign toggle_cnt = toggle_cnt_q;
  assign rare_flag  = rare_flag_q;
  assign stuck_flag = stuck_flag_q;

endmodule
